// File: rtl/alu_issue_stage_if.sv
// ID->EX handshake bundle for the ALU issue stage.
// The master side is the ID producer and EX consumer; the slave side is the stage.
interface alu_issue_stage_if #(
  parameter int unsigned N = 32,
  parameter int unsigned P = 4
);
  logic         id_valid;
  logic         id_ready;
  logic [5:0]   id_opcode;
  logic [5:0]   id_funct;
  logic [N-1:0] id_rs_data;
  logic [N-1:0] id_rt_data;
  logic [15:0]  id_imm;
  logic [4:0]   id_rt;
  logic [4:0]   id_rd;

  logic         ex_valid;
  logic         ex_ready;
  logic [N-1:0] alu_in1;
  logic [N-1:0] alu_in2;
  logic [P-1:0] alu_op;
  logic [4:0]   ex_dest;

  modport master (
    output id_valid, id_opcode, id_funct, id_rs_data, id_rt_data, id_imm, id_rt, id_rd,
    output ex_ready,
    input  id_ready, ex_valid, alu_in1, alu_in2, alu_op, ex_dest
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, id_rs_data, id_rt_data, id_imm, id_rt, id_rd,
    input  ex_ready,
    output id_ready, ex_valid, alu_in1, alu_in2, alu_op, ex_dest
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes opcode/funct into an ALU op, selects operand 2,
// and buffers up to two entries so id_ready stays registered.
module alu_issue_stage #(
  parameter int unsigned N = 32,
  parameter int unsigned P = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus,
  input  logic             flush,
  output logic             illegal,
  output logic [15:0]      issue_count
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [N-1:0]     in1;
    logic [N-1:0]     in2;
    logic [P-1:0]     op;
    logic [REG_W-1:0] dest;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  payload_t         r_main;
  payload_t         r_skid;
  payload_t         w_dec;
  logic             w_legal;
  logic             r_id_ready;
  logic             r_ex_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_issue_count;
  logic             w_accept;
  logic             w_take;
  logic             w_issue;
  logic             w_load_new;
  logic             w_load_skid;
  logic             w_main_from_skid;
  logic [N-1:0]     w_sext;
  logic [N-1:0]     w_zext;

  assign w_sext = {{(N-IMM_W){bus.id_imm[IMM_W-1]}}, bus.id_imm};
  assign w_zext = N'(bus.id_imm);

  // Instruction decode: op code, operand 2 source and destination register
  always_comb begin
    w_legal    = 1'b0;
    w_dec.in1  = bus.id_rs_data;
    w_dec.in2  = bus.id_rt_data;
    w_dec.op   = '0;
    w_dec.dest = '0;
    case (bus.id_opcode)
      6'h00: begin
        w_legal    = 1'b1;
        w_dec.dest = bus.id_rd;
        case (bus.id_funct)
          6'h20:   w_dec.op = P'(4'b0010);
          6'h22:   w_dec.op = P'(4'b0110);
          6'h24:   w_dec.op = P'(4'b0000);
          6'h25:   w_dec.op = P'(4'b0001);
          6'h27:   w_dec.op = P'(4'b1100);
          6'h2A:   w_dec.op = P'(4'b0111);
          default: w_legal  = 1'b0;
        endcase
      end
      6'h08: begin w_legal = 1'b1; w_dec.op = P'(4'b0010); w_dec.in2 = w_sext; w_dec.dest = bus.id_rt; end
      6'h0A: begin w_legal = 1'b1; w_dec.op = P'(4'b0111); w_dec.in2 = w_sext; w_dec.dest = bus.id_rt; end
      6'h0C: begin w_legal = 1'b1; w_dec.op = P'(4'b0000); w_dec.in2 = w_zext; w_dec.dest = bus.id_rt; end
      6'h0D: begin w_legal = 1'b1; w_dec.op = P'(4'b0001); w_dec.in2 = w_zext; w_dec.dest = bus.id_rt; end
      6'h23: begin w_legal = 1'b1; w_dec.op = P'(4'b0010); w_dec.in2 = w_sext; w_dec.dest = bus.id_rt; end
      6'h2B: begin w_legal = 1'b1; w_dec.op = P'(4'b0010); w_dec.in2 = w_sext; end
      6'h04: begin w_legal = 1'b1; w_dec.op = P'(4'b0110); end
      default: ;
    endcase
  end

  // Illegal instructions are accepted but never stored; flush drops the offer
  assign w_accept = bus.id_valid & r_id_ready;
  assign w_take   = w_accept & w_legal & ~flush;
  assign w_issue  = r_ex_valid & bus.ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_take) w_next = S_FULL;
        S_FULL: begin
          if (w_issue && !w_take)      w_next = S_EMPTY;
          else if (!w_issue && w_take) w_next = S_SKID;
        end
        S_SKID:  if (w_issue) w_next = S_FULL;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_load_new       = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (!flush) begin
      case (r_state)
        S_EMPTY: w_load_new = w_take;
        S_FULL: begin
          w_load_new  = w_take & w_issue;
          w_load_skid = w_take & ~w_issue;
        end
        S_SKID:  w_main_from_skid = w_issue;
        default: ;
      endcase
    end
  end

  // Entry storage: main drives the ALU, skid catches one entry while EX stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_new)            r_main <= w_dec;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_ready    <= 1'b1;
      r_ex_valid    <= 1'b0;
      r_illegal     <= 1'b0;
      r_issue_count <= '0;
    end else begin
      r_id_ready <= (w_next != S_SKID);
      r_ex_valid <= (w_next != S_EMPTY);
      r_illegal  <= w_accept & ~w_legal & ~flush;
      if (w_issue) r_issue_count <= r_issue_count + CNT_W'(1);
    end
  end

  assign bus.id_ready = r_id_ready;
  assign bus.ex_valid = r_ex_valid;
  assign bus.alu_in1  = r_main.in1;
  assign bus.alu_in2  = r_main.in2;
  assign bus.alu_op   = r_main.op;
  assign bus.ex_dest  = r_main.dest;
  assign illegal      = r_illegal;
  assign issue_count  = r_issue_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table, skid/flush/reset
// sequences and issue counter wrap, with a queue-based scoreboard on the EX side.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush;
  logic        illegal;
  logic [15:0] issue_count;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.N(32), .P(4)) bus ();

  alu_issue_stage #(.N(32), .P(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush       (flush),
    .illegal     (illegal),
    .issue_count (issue_count)
  );

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  op;
    logic [4:0]  dest;
  } exp_t;

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  rti;
    logic [4:0]  rdi;
    logic        legal;
    logic [31:0] in2;
    logic [3:0]  op;
    logic [4:0]  dest;
  } vec_t;

  localparam int NV = 16;

  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        cur_exp;
  logic        cur_legal = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_illegal = 1'b0;
  logic        mon_en = 1'b0;
  vec_t        vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] opc, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] imm, input logic [4:0] rti,
                              input logic [4:0] rdi, input logic legal,
                              input logic [31:0] in2, input logic [3:0] op,
                              input logic [4:0] dest);
    vec_t v;
    v.opc = opc; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = imm; v.rti = rti;
    v.rdi = rdi; v.legal = legal; v.in2 = in2; v.op = op; v.dest = dest;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_opcode  = v.opc;
    bus.id_funct   = v.fn;
    bus.id_rs_data = v.rs;
    bus.id_rt_data = v.rt;
    bus.id_imm     = v.imm;
    bus.id_rt      = v.rti;
    bus.id_rd      = v.rdi;
    cur_legal      = v.legal;
    cur_exp.in1    = v.rs;
    cur_exp.in2    = v.in2;
    cur_exp.op     = v.op;
    cur_exp.dest   = v.dest;
  endtask

  task automatic check_reset_outputs();
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_id_ready", 32'(bus.id_ready), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu_in1", bus.alu_in1, 32'd0);
    check("rst_alu_in2", bus.alu_in2, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_ex_dest", 32'(bus.ex_dest), 32'd0);
    check("rst_issue_count", 32'(issue_count), 32'd0);
  endtask

  task automatic do_reset();
    mon_en       = 1'b0;
    bus.id_valid = 1'b0;
    flush        = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n       = 1'b1;
    sb.delete();
    exp_cnt     = 16'd0;
    exp_illegal = 1'b0;
    cur_legal   = 1'b0;
    mon_en      = 1'b1;
  endtask

  // One instruction from an empty stage with EX always ready
  task automatic send_one(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    bus.id_valid = 1'b1;
    @(posedge clk); #1;
    bus.id_valid = 1'b0;
    check("latency_ex_valid", 32'(bus.ex_valid), 32'(v.legal));
    @(posedge clk); #1;
    check("drained_ex_valid", 32'(bus.ex_valid), 32'd0);
  endtask

  // Scoreboard: push on accept, pop and compare on issue, track counter and illegal pulse
  always @(negedge clk) begin
    exp_t e;
    logic acc;
    if (rst_n && mon_en) begin
      check("illegal", 32'(illegal), 32'(exp_illegal));
      check("issue_count", 32'(issue_count), 32'(exp_cnt));
      if (bus.ex_valid && bus.ex_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_issue: got an issue, expected none queued");
        end else begin
          e = sb.pop_front();
          check("alu_in1", bus.alu_in1, e.in1);
          check("alu_in2", bus.alu_in2, e.in2);
          check("alu_op", 32'(bus.alu_op), 32'(e.op));
          check("ex_dest", 32'(bus.ex_dest), 32'(e.dest));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      acc         = bus.id_valid && bus.id_ready && !flush;
      exp_illegal = acc && !cur_legal;
      if (flush) sb.delete();
      else if (acc && cur_legal) sb.push_back(cur_exp);
    end
  end

  initial begin
    vec_t va, vb, vc, vill;

    vecs[0]  = mk(6'h00, 6'h20, 32'd5,   32'd7,      16'h0000, 5'd2,  5'd3,  1'b1, 32'd7,        4'b0010, 5'd3);
    vecs[1]  = mk(6'h08, 6'h00, 32'd10,  32'h1234,   16'hFFFF, 5'd4,  5'd9,  1'b1, 32'hFFFFFFFF, 4'b0010, 5'd4);
    vecs[2]  = mk(6'h0C, 6'h00, 32'd10,  32'h1234,   16'hFFFF, 5'd6,  5'd9,  1'b1, 32'h0000FFFF, 4'b0000, 5'd6);
    vecs[3]  = mk(6'h00, 6'h22, 32'd100, 32'd40,     16'h0000, 5'd1,  5'd8,  1'b1, 32'd40,       4'b0110, 5'd8);
    vecs[4]  = mk(6'h00, 6'h24, 32'hFF,  32'hF0F0,   16'h0000, 5'd1,  5'd9,  1'b1, 32'hF0F0,     4'b0000, 5'd9);
    vecs[5]  = mk(6'h00, 6'h25, 32'hFF,  32'hF0F1,   16'h0000, 5'd1,  5'd10, 1'b1, 32'hF0F1,     4'b0001, 5'd10);
    vecs[6]  = mk(6'h00, 6'h27, 32'h11,  32'h22,     16'h0000, 5'd1,  5'd11, 1'b1, 32'h22,       4'b1100, 5'd11);
    vecs[7]  = mk(6'h00, 6'h2A, 32'h33,  32'h44,     16'h0000, 5'd1,  5'd12, 1'b1, 32'h44,       4'b0111, 5'd12);
    vecs[8]  = mk(6'h0A, 6'h00, 32'h55,  32'h66,     16'h8000, 5'd13, 5'd1,  1'b1, 32'hFFFF8000, 4'b0111, 5'd13);
    vecs[9]  = mk(6'h0D, 6'h00, 32'h77,  32'h88,     16'h8001, 5'd14, 5'd1,  1'b1, 32'h00008001, 4'b0001, 5'd14);
    vecs[10] = mk(6'h23, 6'h00, 32'h1000, 32'h99,    16'h0004, 5'd15, 5'd1,  1'b1, 32'h00000004, 4'b0010, 5'd15);
    vecs[11] = mk(6'h2B, 6'h00, 32'h2000, 32'hAA,    16'hFFFC, 5'd16, 5'd1,  1'b1, 32'hFFFFFFFC, 4'b0010, 5'd0);
    vecs[12] = mk(6'h04, 6'h00, 32'h3000, 32'hDEAD,  16'h0010, 5'd17, 5'd2,  1'b1, 32'h0000DEAD, 4'b0110, 5'd0);
    vecs[13] = mk(6'h3F, 6'h00, 32'h1,   32'h2,      16'h0000, 5'd3,  5'd4,  1'b0, 32'h0,        4'b0000, 5'd0);
    vecs[14] = mk(6'h00, 6'h21, 32'h1,   32'h2,      16'h0000, 5'd3,  5'd4,  1'b0, 32'h0,        4'b0000, 5'd0);
    vecs[15] = mk(6'h08, 6'h00, 32'h4,   32'h5,      16'h7FFF, 5'd18, 5'd4,  1'b1, 32'h00007FFF, 4'b0010, 5'd18);

    va   = mk(6'h00, 6'h20, 32'd1, 32'd2, 16'h0000, 5'd0, 5'd5, 1'b1, 32'd2, 4'b0010, 5'd5);
    vb   = mk(6'h00, 6'h22, 32'd3, 32'd1, 16'h0000, 5'd0, 5'd6, 1'b1, 32'd1, 4'b0110, 5'd6);
    vc   = mk(6'h00, 6'h25, 32'd9, 32'd9, 16'h0000, 5'd0, 5'd7, 1'b1, 32'd9, 4'b0001, 5'd7);
    vill = mk(6'h3F, 6'h00, 32'd0, 32'd0, 16'h0000, 5'd0, 5'd0, 1'b0, 32'd0, 4'b0000, 5'd0);

    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    flush        = 1'b0;
    drive(va);
    cur_legal = 1'b0;
    #2;
    do_reset();

    bus.ex_ready = 1'b1;
    for (int i = 0; i < NV; i++) send_one(vecs[i]);

    // Stall EX: two accepted, third held off, outputs frozen on the first
    bus.ex_ready = 1'b0;
    @(posedge clk); #1; drive(va); bus.id_valid = 1'b1;
    @(posedge clk); #1; drive(vb);
    check("full_id_ready", 32'(bus.id_ready), 32'd1);
    @(posedge clk); #1; drive(vc);
    check("skid_id_ready", 32'(bus.id_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_id_ready", 32'(bus.id_ready), 32'd0);
      check("stall_ex_valid", 32'(bus.ex_valid), 32'd1);
      check("stall_alu_in1", bus.alu_in1, 32'd1);
      check("stall_alu_in2", bus.alu_in2, 32'd2);
      check("stall_alu_op", 32'(bus.alu_op), 32'b0010);
      check("stall_ex_dest", 32'(bus.ex_dest), 32'd5);
    end
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    @(posedge clk); #1;
    check("unskid_id_ready", 32'(bus.id_ready), 32'd1);
    check("unskid_alu_in1", bus.alu_in1, 32'd3);
    @(posedge clk); #1;
    check("unskid_drained", 32'(bus.ex_valid), 32'd0);
    check("unskid_sb_empty", 32'(sb.size()), 32'd0);

    // Flush while in SKID with a new offer
    bus.ex_ready = 1'b0;
    @(posedge clk); #1; drive(va); bus.id_valid = 1'b1;
    @(posedge clk); #1; drive(vb);
    @(posedge clk); #1; drive(vc); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; bus.id_valid = 1'b0;
    check("flush_skid_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_skid_id_ready", 32'(bus.id_ready), 32'd1);
    check("flush_skid_sb_empty", 32'(sb.size()), 32'd0);
    bus.ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_skid_idle", 32'(bus.ex_valid), 32'd0);

    // Flush in FULL with a same-cycle issue and an illegal offer
    bus.ex_ready = 1'b0;
    @(posedge clk); #1; drive(va); bus.id_valid = 1'b1;
    @(posedge clk); #1; drive(vill); flush = 1'b1; bus.ex_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; bus.id_valid = 1'b0;
    check("flush_full_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_full_id_ready", 32'(bus.id_ready), 32'd1);
    @(posedge clk); #1;
    check("flush_full_no_illegal", 32'(illegal), 32'd0);

    // Flush in EMPTY drops a legal offer
    @(posedge clk); #1; drive(va); bus.id_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; bus.id_valid = 1'b0;
    check("flush_empty_ex_valid", 32'(bus.ex_valid), 32'd0);

    // Asynchronous reset in the middle of a stall
    bus.ex_ready = 1'b0;
    @(posedge clk); #1; drive(va); bus.id_valid = 1'b1;
    @(posedge clk); #1; drive(vb);
    @(posedge clk); #3;
    do_reset();

    // 65536 issues wrap the counter back to zero
    bus.ex_ready = 1'b1;
    @(posedge clk); #1; drive(vecs[0]); bus.id_valid = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("wrap_issue_count", 32'(issue_count), 32'd0);
    check("wrap_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
